avalon_test_mailbox: RTL
========================

# avalon_test_mailbox

Parametrised Avalon-MM slave inside `picorv32_soc` that carries simulation and bring-up traffic between the bench and firmware. The bench loads N argument words and pulses a start; firmware reads the arguments, posts a result and a pass/fail verdict, and drives the LED bank. The block raises `rdy` with the result on dedicated pins and counts run cycles. It generalises the single `x`/`y`/`rdy`/`LED` exchange to N arguments, configurable widths, a verdict and an optional watchdog.

## Interface
Parameters:
- `DATA_W`, 32: register and bus data width; multiple of 8.
- `N_ARGS`, 4: number of argument registers, 1..(2^ADDR_W − 4).
- `ADDR_W`, 4: Avalon word-address width.
- `LED_W`, 8: LED register width, ≤ DATA_W.
- `TIMEOUT_CYCLES`, 100000: watchdog limit in RUN cycles.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `avs_address`  in  ADDR_W  word address.
- `avs_read`, `avs_write`  in  1  access strobes.
- `avs_writedata`  in  DATA_W  write data.
- `avs_byteenable`  in  DATA_W/8  write byte lanes.
- `avs_readdata`  out  DATA_W  read data.
- `avs_readdatavalid`  out  1  read data qualifier.
- `avs_waitrequest`  out  1  stall.
- `host_args`  in  N_ARGS*DATA_W  bench arguments; arg i is at [i*DATA_W +: DATA_W].
- `host_start`  in  1  one-cycle start pulse.
- `LED`  out  LED_W  LED register.
- `rdy`  out  1  run finished (verdict or timeout).
- `y`  out  DATA_W  RESULT register.
- `pass`  out  1  firmware verdict.
- `timed_out`  out  1  watchdog fired.
- `cycles`  out  DATA_W  RUN cycle count.

## Operation
- Word map:
  - 0 CTRL/STATUS.
  - 1 RESULT (R/W).
  - 2 LED (R/W, low LED_W bits).
  - 3 CYCLES (RO).
  - 4..4+N_ARGS−1 ARG[i] (RO).
  - Unmapped reads return 0; unmapped writes and writes to RO words are ignored.
- STATUS read layout: bit0 = running, bit1 = rdy, bit2 = pass, bit3 = timed_out, bits[15:8] = N_ARGS; other bits 0.
- CTRL write: bit0 = 1 declares done, bit1 = verdict. Byteenable[0] must be set, otherwise the write is ignored.
- RESULT, LED: byteenable-masked writes.
- FSM states are IDLE, RUN, DONE, TIMEOUT.
- `host_start` from any state:
  - latches all `host_args` into ARG;
  - clears rdy, pass, timed_out, cycles;
  - goes to RUN.
  - RESULT and LED are not cleared.
- RUN + CTRL done write: go to DONE, set `rdy`=1, set `pass` = bit1.
- CTRL done write outside RUN: ignored.
- `cycles` increments once per RUN cycle and saturates at all-ones.
- Simultaneous `host_start` and CTRL done write: `host_start` wins; the write is dropped.
- Reset mid-run returns the block to IDLE with all registers cleared; no completion is signalled.

## Timing
- Reset values:
  - all outputs 0, except `avs_waitrequest` = 1;
  - ARG, RESULT, LED, cycles = 0;
  - state IDLE.
- `avs_waitrequest` stays 1 during reset and for the first clock after reset deasserts, then stays 0.
- Reads: fixed latency 1. `avs_readdata` and `avs_readdatavalid` are registered; valid is a single-cycle pulse. Data is 0 when not valid.
- Writes complete in the accept cycle. The register value is visible on outputs and readback from the next cycle.
- `rdy` and `pass` are registered and assert the cycle after the CTRL write is accepted.
- ARG is readable the cycle after `host_start`.

## Configuration
- `MAILBOX_WATCHDOG_EN`:
  - Defined: in RUN, when `cycles` reaches TIMEOUT_CYCLES, go to TIMEOUT on the next edge with `rdy`=1, `timed_out`=1, `pass`=0. If a CTRL done write arrives in the same cycle, DONE wins.
  - Undefined: no TIMEOUT state; `timed_out` and STATUS bit3 are tied to 0; TIMEOUT_CYCLES is unused.

## Test plan
- Reset, then release → `avs_waitrequest` is 1 for one clock after release; `LED`, `y`, `rdy` = 0; STATUS reads 0x00000400 (N_ARGS=4).
- `host_args` = {4,3,2,1}, start pulse; read words 4..7 → 1, 2, 3, 4, each valid exactly one cycle after its read.
- In RUN, write RESULT=0x2A, then CTRL=0x3 → the next cycle `y`=0x2A, `rdy`=1, `pass`=1; STATUS=0x406.
- Write LED 0x1A5 with byteenable=0b0001 → `LED`=0xA5; a second start pulse keeps `LED`=0xA5 and `y` unchanged, and clears `rdy`.
- CTRL done write in the same cycle as `host_start` → state is RUN and `rdy`=0. With the watchdog enabled and TIMEOUT_CYCLES=50, no CTRL write → `rdy`=1, `timed_out`=1, `pass`=0, `cycles`=50.
- Assert `reset` mid-RUN at cycles=20 → all outputs return to reset values asynchronously; STATUS reads 0x400 after recovery.

Source files
------------

// File: rtl/avalon_test_mailbox.sv
// avalon_test_mailbox: Avalon-MM test mailbox between the bench and firmware.
// The bench loads N_ARGS argument words and pulses host_start. Firmware reads
// the arguments, posts RESULT and a verdict through CTRL, and drives the LEDs.
// The block raises rdy and counts the cycles spent in RUN.
//
// Optional feature macro: MAILBOX_WATCHDOG_EN
//   When defined, a run that lasts TIMEOUT_CYCLES cycles is ended by a
//   watchdog (TIMEOUT state). When undefined, timed_out is tied low.
//
// Word map: 0 CTRL/STATUS, 1 RESULT, 2 LED, 3 CYCLES, 4.. ARG[i] (read-only).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | out of reset, no run started yet
// RUN     | arguments latched, waiting for firmware to declare done
// DONE    | firmware posted its verdict, rdy high
// TIMEOUT | watchdog ended the run, rdy and timed_out high, pass low
module avalon_test_mailbox #(
    parameter int DATA_W         = 32,
    parameter int N_ARGS         = 4,
    parameter int ADDR_W         = 4,
    parameter int LED_W          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [DATA_W-1:0]        avs_writedata,
    input  logic [DATA_W/8-1:0]      avs_byteenable,
    output logic [DATA_W-1:0]        avs_readdata,
    output logic                     avs_readdatavalid,
    output logic                     avs_waitrequest,
    input  logic [N_ARGS*DATA_W-1:0] host_args,
    input  logic                     host_start,
    output logic [LED_W-1:0]         LED,
    output logic                     rdy,
    output logic [DATA_W-1:0]        y,
    output logic                     pass,
    output logic                     timed_out,
    output logic [DATA_W-1:0]        cycles
);

    localparam int BE_W = DATA_W / 8;

`ifdef MAILBOX_WATCHDOG_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] TIMEOUT_VAL = DATA_W'(TIMEOUT_CYCLES);
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Watchdog limit has no function in this build.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

    state_t             state;
    logic               wait_q;
    logic [DATA_W-1:0]  result_q;
    logic [LED_W-1:0]   led_q;
    logic [LED_W-1:0]   led_next;
    logic [DATA_W-1:0]  arg_q [N_ARGS];
    logic               rdy_q;
    logic               pass_q;
    logic               to_q;
    logic [DATA_W-1:0]  cycles_q;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  status_word;
    logic               rd_acc;
    logic               wr_acc;
    logic               done_wr;
    logic               wdog_hit;

    // A transfer is only taken once the post-reset stall has been released.
    assign rd_acc  = avs_read  & ~wait_q;
    assign wr_acc  = avs_write & ~wait_q;
    assign done_wr = wr_acc && (avs_address == ADDR_W'(0)) &&
                     avs_byteenable[0] && avs_writedata[0];

`ifdef MAILBOX_WATCHDOG_EN
    assign wdog_hit = (state == RUN) && (cycles_q == TIMEOUT_VAL);
`else
    assign wdog_hit = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] wd,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_val;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // Stall the bus from reset until the first clock edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_q <= 1'b1;
        else       wait_q <= 1'b0;
    end

    // Byte-lane merge for the LED register; only the low LED_W bits exist.
    always_comb begin
        led_next = led_q;
        for (int i = 0; i < LED_W; i++) begin
            if (avs_byteenable[i/8]) led_next[i] = avs_writedata[i];
        end
    end

    // Firmware-writable RESULT and LED registers; untouched by host_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            led_q    <= '0;
        end else if (wr_acc) begin
            if (avs_address == ADDR_W'(1))
                result_q <= be_merge(result_q, avs_writedata, avs_byteenable);
            if (avs_address == ADDR_W'(2))
                led_q <= led_next;
        end
    end

    // Run sequencing: start latches arguments, done write or watchdog ends it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rdy_q    <= 1'b0;
            pass_q   <= 1'b0;
            to_q     <= 1'b0;
            cycles_q <= '0;
            for (int i = 0; i < N_ARGS; i++) arg_q[i] <= '0;
        end else if (host_start) begin
            // Start has priority over a done write arriving in the same cycle.
            state    <= RUN;
            rdy_q    <= 1'b0;
            pass_q   <= 1'b0;
            to_q     <= 1'b0;
            cycles_q <= '0;
            for (int i = 0; i < N_ARGS; i++)
                arg_q[i] <= host_args[i*DATA_W +: DATA_W];
        end else if (state == RUN) begin
            if (!wdog_hit && (cycles_q != '1))
                cycles_q <= cycles_q + 1'b1;
            if (done_wr) begin
                state  <= DONE;
                rdy_q  <= 1'b1;
                pass_q <= avs_writedata[1];
            end
`ifdef MAILBOX_WATCHDOG_EN
            else if (wdog_hit) begin
                state  <= TIMEOUT;
                rdy_q  <= 1'b1;
                pass_q <= 1'b0;
                to_q   <= 1'b1;
            end
`endif
        end
    end

    // STATUS word assembled from the live run flags.
    always_comb begin
        status_word       = '0;
        status_word[0]    = (state == RUN);
        status_word[1]    = rdy_q;
        status_word[2]    = pass_q;
        status_word[3]    = to_q;
        status_word[15:8] = 8'(N_ARGS);
    end

    // Read mux; unmapped words return zero.
    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_W'(0): rd_word = status_word;
            ADDR_W'(1): rd_word = result_q;
            ADDR_W'(2): rd_word = DATA_W'(led_q);
            ADDR_W'(3): rd_word = cycles_q;
            default:    rd_word = '0;
        endcase
        for (int i = 0; i < N_ARGS; i++) begin
            if (avs_address == ADDR_W'(4 + i)) rd_word = arg_q[i];
        end
    end

    // Registered read response: one-cycle latency, data zero when not valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= rd_acc;
            avs_readdata      <= rd_acc ? rd_word : '0;
        end
    end

    assign avs_waitrequest = wait_q;
    assign LED             = led_q;
    assign y               = result_q;
    assign rdy             = rdy_q;
    assign pass            = pass_q;
    assign timed_out       = to_q;
    assign cycles          = cycles_q;

endmodule
